// File: rtl/spi_cmd_seq_if.sv
// Host-side command/response channels of the SPI command sequencer.
// The host drives commands and response acceptance; the sequencer returns readiness and responses.
interface spi_cmd_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_wr;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;

    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_wr;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_err, rsp_timeout
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_err, rsp_timeout
    );
endinterface

// File: rtl/spi_cmd_seq.sv
// Command sequencer in front of the SPI controller/memory pair: queues host commands,
// issues one at a time with the controller held in reset between commands, and returns a response each.
module spi_cmd_seq #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    spi_cmd_seq_if.slave           host,
    output logic                   ctl_rst_n,
    output logic                   ctl_wr,
    output logic [7:0]             ctl_addr,
    output logic [7:0]             ctl_din,
    input  logic                   ctl_done,
    input  logic                   ctl_err,
    input  logic [7:0]             ctl_dout,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int              AW        = $clog2(DEPTH);
    localparam int              ENTRY_W   = 17;
    localparam logic [AW:0]     FULL      = (AW+1)'(DEPTH);
    localparam logic [15:0]     TIMER_MAX = 16'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state;
    logic [ENTRY_W-1:0]   fifo_mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic [ENTRY_W-1:0]   head;
    logic                 push;
    logic                 pop;
    logic                 cmd_ready;
    logic [15:0]          timer;

    logic                 rsp_valid;
    logic                 rsp_wr;
    logic [7:0]           rsp_rdata;
    logic                 rsp_err;
    logic                 rsp_timeout;

    // Read data is only meaningful for a successful read; writes and errors return zero.
    function automatic logic [7:0] read_data(input logic wr, input logic err, input logic [7:0] dout);
        return (!wr && !err) ? dout : 8'h00;
    endfunction

    assign cmd_ready  = (count != FULL);
    assign push       = host.cmd_valid && cmd_ready;
    assign pop        = (state == IDLE) && (count != '0);
    assign head       = fifo_mem[rd_ptr];
    assign busy       = (state != IDLE) || (count != '0);
    assign fifo_count = count;

    assign host.cmd_ready   = cmd_ready;
    assign host.rsp_valid   = rsp_valid;
    assign host.rsp_wr      = rsp_wr;
    assign host.rsp_rdata   = rsp_rdata;
    assign host.rsp_err     = rsp_err;
    assign host.rsp_timeout = rsp_timeout;

    // Command queue: storage is not reset, only the pointers and occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {host.cmd_wr, host.cmd_addr, host.cmd_wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sequencer: controller reset is released only while a command is in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            ctl_rst_n   <= 1'b0;
            ctl_wr      <= 1'b0;
            ctl_addr    <= 8'h00;
            ctl_din     <= 8'h00;
            rsp_valid   <= 1'b0;
            rsp_wr      <= 1'b0;
            rsp_rdata   <= 8'h00;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ctl_rst_n <= 1'b0;
                    if (pop) begin
                        ctl_wr   <= head[16];
                        ctl_addr <= head[15:8];
                        ctl_din  <= head[7:0];
                        rsp_wr   <= head[16];
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    ctl_rst_n <= 1'b1;
                    timer     <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // A completion in the expiry cycle still counts as a normal completion.
                    if (ctl_done) begin
                        rsp_err     <= ctl_err;
                        rsp_rdata   <= read_data(ctl_wr, ctl_err, ctl_dout);
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        ctl_rst_n   <= 1'b0;
                        state       <= RESP;
                    end else if (timer == TIMER_MAX) begin
                        rsp_err     <= 1'b1;
                        rsp_rdata   <= 8'h00;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        ctl_rst_n   <= 1'b0;
                        state       <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    ctl_rst_n <= 1'b0;
                    if (host.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    ctl_rst_n <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Bench for spi_cmd_seq: behavioural SPI controller/memory stand-in, directed vector table,
// multi-cycle corner sequences and a randomized run scored against a reference model.
module tb_spi_cmd_seq;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    typedef struct {
        logic       wr;
        logic [7:0] rdata;
        logic       err;
        logic       timeout;
        logic       rst_n;
    } rsp_t;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         lat;
        bit         hang;
        logic [7:0] e_rdata;
        logic       e_err;
        logic       e_to;
        int         e_wait;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ctl_rst_n;
    logic       ctl_wr;
    logic [7:0] ctl_addr;
    logic [7:0] ctl_din;
    logic       ctl_done = 1'b0;
    logic       ctl_err  = 1'b0;
    logic [7:0] ctl_dout = 8'h00;
    logic       busy;
    logic [2:0] fifo_count;

    spi_cmd_seq_if tb_if ();

    spi_cmd_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .host       (tb_if),
        .ctl_rst_n  (ctl_rst_n),
        .ctl_wr     (ctl_wr),
        .ctl_addr   (ctl_addr),
        .ctl_din    (ctl_din),
        .ctl_done   (ctl_done),
        .ctl_err    (ctl_err),
        .ctl_dout   (ctl_dout),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_err    = 0;
    int   ctl_lat  = 1;
    bit   ctl_hang = 1'b0;
    int   rdy_mode = 0;
    rsp_t exp_q[$];
    rsp_t got_q[$];
    logic [7:0] c_mem   [32] = '{default: 8'h00};
    logic [7:0] ref_mem [32] = '{default: 8'h00};
    vec_t tbl [11];

    // Controller/memory stand-in: completes ctl_lat+1 cycles after reset release unless hung.
    int m_cnt   = 0;
    bit m_fired = 1'b0;
    always @(posedge clk) begin
        ctl_done <= 1'b0;
        if (!ctl_rst_n) begin
            m_cnt   <= 0;
            m_fired <= 1'b0;
        end else if (!m_fired) begin
            m_cnt <= m_cnt + 1;
            if (!ctl_hang && m_cnt >= ctl_lat) begin
                m_fired  <= 1'b1;
                ctl_done <= 1'b1;
                if (ctl_addr >= 8'd32) begin
                    ctl_err  <= 1'b1;
                    ctl_dout <= 8'($urandom);
                end else begin
                    ctl_err <= 1'b0;
                    if (ctl_wr) begin
                        c_mem[ctl_addr[4:0]] <= ctl_din;
                        ctl_dout             <= 8'($urandom);
                    end else begin
                        ctl_dout <= c_mem[ctl_addr[4:0]];
                    end
                end
            end
        end
    end

    // Response sink: owns rsp_ready and records every accepted response.
    always @(negedge clk) begin
        logic r;
        case (rdy_mode)
            0:       r = 1'b0;
            1:       r = 1'b1;
            default: r = ($urandom_range(0, 3) != 0);
        endcase
        tb_if.rsp_ready = r;
        if (tb_if.rsp_valid && r) begin
            got_q.push_back('{tb_if.rsp_wr, tb_if.rsp_rdata, tb_if.rsp_err, tb_if.rsp_timeout, ctl_rst_n});
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, got running required finished");
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_rsp(input string pfx, input rsp_t g, input rsp_t e);
        check({pfx, "_wr"},      32'(g.wr),      32'(e.wr));
        check({pfx, "_rdata"},   32'(g.rdata),   32'(e.rdata));
        check({pfx, "_err"},     32'(g.err),     32'(e.err));
        check({pfx, "_timeout"}, 32'(g.timeout), 32'(e.timeout));
    endtask

    // Reference: a 32-byte memory; addresses >= 32 fail; a stalled command times out.
    function automatic rsp_t ref_exec(input logic wr, input logic [7:0] a, input logic [7:0] d,
                                      input bit timed_out);
        rsp_t r;
        r.wr = wr;
        r.rst_n = 1'b0;
        if (timed_out) begin
            r.rdata = 8'h00; r.err = 1'b1; r.timeout = 1'b1;
        end else if (a >= 8'd32) begin
            r.rdata = 8'h00; r.err = 1'b1; r.timeout = 1'b0;
        end else begin
            r.err = 1'b0; r.timeout = 1'b0;
            if (wr) begin
                ref_mem[a[4:0]] = d;
                r.rdata = 8'h00;
            end else begin
                r.rdata = ref_mem[a[4:0]];
            end
        end
        return r;
    endfunction

    task automatic push_cmd(input logic wr, input logic [7:0] a, input logic [7:0] d,
                            input int tries, output bit ok);
        ok = 1'b0;
        tb_if.cmd_wr    = wr;
        tb_if.cmd_addr  = a;
        tb_if.cmd_wdata = d;
        tb_if.cmd_valid = 1'b1;
        for (int i = 0; i < tries && !ok; i++) begin
            if (tb_if.cmd_ready) ok = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        tb_if.cmd_valid = 1'b0;
        if (ok) exp_q.push_back(ref_exec(wr, a, d, ctl_hang || (ctl_lat + 1 > TIMEOUT)));
    endtask

    task automatic run_one(input int idx, input vec_t v);
        bit   ok;
        bit   got;
        int   hi;
        rsp_t g;
        rsp_t e;
        string p;
        p = $sformatf("vec%0d", idx);
        ctl_lat  = v.lat;
        ctl_hang = v.hang;
        rdy_mode = 1;
        push_cmd(v.wr, v.addr, v.wdata, 20, ok);
        exp_q.delete();
        check({p, "_accept"}, 32'(ok), 32'd1);
        #1;
        check({p, "_rstn_before"}, 32'(ctl_rst_n), 32'd0);
        hi  = 0;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            if (got_q.size() > 0) begin
                g   = got_q.pop_front();
                got = 1'b1;
            end else begin
                if (ctl_rst_n) hi++;
                @(negedge clk);
                #1;
            end
        end
        check({p, "_got_rsp"}, 32'(got), 32'd1);
        if (got) begin
            e = '{v.wr, v.e_rdata, v.e_err, v.e_to, 1'b0};
            cmp_rsp(p, g, e);
            check({p, "_rstn_after"}, 32'(g.rst_n), 32'd0);
            check({p, "_wait_cycles"}, 32'(hi), 32'(v.e_wait));
        end
        @(negedge clk);
        #1;
        check({p, "_rsp_drop"}, 32'(tb_if.rsp_valid), 32'd0);
        ctl_hang = 1'b0;
    endtask

    initial begin
        bit   ok;
        int   acc;
        int   n;
        bit   seen;
        rsp_t g;
        rsp_t e;

        tbl[0]  = '{1'b1, 8'h05, 8'hA5, 2,  1'b0, 8'h00, 1'b0, 1'b0, 4};
        tbl[1]  = '{1'b0, 8'h05, 8'h00, 3,  1'b0, 8'hA5, 1'b0, 1'b0, 5};
        tbl[2]  = '{1'b1, 8'h28, 8'h11, 1,  1'b0, 8'h00, 1'b1, 1'b0, 3};
        tbl[3]  = '{1'b0, 8'h05, 8'h00, 0,  1'b0, 8'hA5, 1'b0, 1'b0, 2};
        tbl[4]  = '{1'b0, 8'h03, 8'h00, 1,  1'b1, 8'h00, 1'b1, 1'b1, 16};
        tbl[5]  = '{1'b1, 8'h03, 8'h5A, 2,  1'b0, 8'h00, 1'b0, 1'b0, 4};
        tbl[6]  = '{1'b0, 8'h03, 8'h00, 14, 1'b0, 8'h5A, 1'b0, 1'b0, 16};
        tbl[7]  = '{1'b0, 8'h03, 8'h00, 15, 1'b0, 8'h00, 1'b1, 1'b1, 16};
        tbl[8]  = '{1'b0, 8'hC0, 8'h00, 1,  1'b0, 8'h00, 1'b1, 1'b0, 3};
        tbl[9]  = '{1'b1, 8'h1F, 8'h3C, 4,  1'b0, 8'h00, 1'b0, 1'b0, 6};
        tbl[10] = '{1'b0, 8'h1F, 8'h00, 1,  1'b0, 8'h3C, 1'b0, 1'b0, 3};

        tb_if.cmd_valid = 1'b0;
        tb_if.cmd_wr    = 1'b0;
        tb_if.cmd_addr  = 8'h00;
        tb_if.cmd_wdata = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_cmd_ready",   32'(tb_if.cmd_ready),   32'd1);
        check("rst_fifo_count",  32'(fifo_count),        32'd0);
        check("rst_busy",        32'(busy),              32'd0);
        check("rst_rsp_valid",   32'(tb_if.rsp_valid),   32'd0);
        check("rst_rsp_wr",      32'(tb_if.rsp_wr),      32'd0);
        check("rst_rsp_rdata",   32'(tb_if.rsp_rdata),   32'd0);
        check("rst_rsp_err",     32'(tb_if.rsp_err),     32'd0);
        check("rst_rsp_timeout", 32'(tb_if.rsp_timeout), 32'd0);
        check("rst_ctl_rst_n",   32'(ctl_rst_n),         32'd0);
        check("rst_ctl_fields",  32'({ctl_wr, ctl_addr, ctl_din}), 32'd0);
        @(negedge clk);

        // Directed vectors, one command at a time; reference memory follows along.
        for (int i = 0; i < 11; i++) begin
            void'(ref_exec(tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                           tbl[i].hang || (tbl[i].lat + 1 > TIMEOUT)));
            run_one(i, tbl[i]);
        end

        // Full queue: DEPTH entries plus one in flight, response held off.
        rdy_mode = 0;
        ctl_lat  = 1;
        got_q.delete();
        exp_q.delete();
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) push_cmd(1'b1, 8'(8 + i), 8'(8'h30 + i), 1, ok);
            else       push_cmd(1'b0, 8'(8 + i - 3), 8'h00, 1, ok);
            if (ok) acc++;
        end
        check("full_accepted", 32'(acc), 32'd5);
        check("full_count", 32'(fifo_count), 32'(DEPTH));
        check("full_cmd_ready", 32'(tb_if.cmd_ready), 32'd0);
        push_cmd(1'b0, 8'h01, 8'h00, 1, ok);
        check("full_sixth_rejected", 32'(ok), 32'd0);
        rdy_mode = 1;
        for (int c = 0; c < 500 && got_q.size() < 5; c++) @(negedge clk);
        #1;
        check("full_rsp_count", 32'(got_q.size()), 32'd5);
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            cmp_rsp($sformatf("full%0d", n), g, e);
            n++;
        end
        for (int c = 0; c < 20 && busy; c++) begin
            @(negedge clk);
            #1;
        end
        check("full_drain_count", 32'(fifo_count), 32'd0);
        check("full_drain_busy",  32'(busy),       32'd0);

        // Randomized traffic with random response backpressure.
        rdy_mode = 2;
        got_q.delete();
        exp_q.delete();
        n = 40;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            logic       wr;
            logic [7:0] a;
            wr = 1'($urandom);
            a  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
            ctl_lat = $urandom_range(0, 6);
            push_cmd(wr, a, 8'($urandom), 200, ok);
            if (!ok) begin
                n_checks++;
                n_err++;
                $display("FAIL rand_push%0d: got not_accepted expected accepted", i);
            end else begin
                acc++;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int c = 0; c < 5000 && got_q.size() < acc; c++) @(negedge clk);
        #1;
        check("rand_rsp_count", 32'(got_q.size()), 32'(acc));
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            cmp_rsp($sformatf("rand%0d", n), g, e);
            n++;
        end
        for (int c = 0; c < 50 && busy; c++) @(negedge clk);

        // Reset mid-WAIT with three commands queued behind the in-flight one.
        @(negedge clk);
        rdy_mode = 0;
        ctl_lat  = 10;
        got_q.delete();
        for (int i = 0; i < 4; i++) push_cmd(1'b0, 8'(i), 8'h00, 1, ok);
        exp_q.delete();
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (ctl_rst_n) seen = 1'b1;
            else @(negedge clk);
        end
        check("rstmid_reached_wait", 32'(seen), 32'd1);
        check("rstmid_queued", 32'(fifo_count), 32'd3);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_ctl_rst_n", 32'(ctl_rst_n),  32'd0);
        check("rstmid_count",     32'(fifo_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rdy_mode = 1;
        #1;
        check("rstmid_cmd_ready", 32'(tb_if.cmd_ready), 32'd1);
        check("rstmid_busy",      32'(busy),            32'd0);
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            #1;
            if (tb_if.rsp_valid || ctl_rst_n) seen = 1'b1;
        end
        check("rstmid_no_rsp", 32'(seen), 32'd0);
        check("rstmid_no_capture", 32'(got_q.size()), 32'd0);
        @(negedge clk);
        void'(ref_exec(tbl[1].wr, tbl[1].addr, tbl[1].wdata, 1'b0));
        run_one(99, tbl[1]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
